// File: rtl/mc_controller_pkg.sv
// Purpose : shared types and constants for the multicycle RISC-V control unit.
// Latency : n/a (package only).
// Backpressure: n/a. Holds the state enum, ALUControl / ImmSrc codes, mux selects and opcodes.
package mc_ctrl_pkg;

  // Encoding order is visible on the State debug output; keep it stable.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_e;

  // ALUControl codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_PASSB = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;

  // ImmSrc codes
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Mux selects
  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_RS1      = 2'b10;
  localparam logic [1:0] SRCB_RS2      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_RESULT    = 1'b1;

  // Opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  function automatic logic op_is_legal(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRNCH) || (op == OP_JAL)   ||
           (op == OP_LUI);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Purpose : bundle of instruction fields / flags in and control selects out of the controller.
// Latency : n/a (wires only).
// Backpressure: none; master = controller (drives controls), slave = datapath (drives fields).
interface mc_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State
  );
endinterface

// File: rtl/mc_controller_alu_dec.sv
// Purpose : funct3/funct7 decode to ALUControl for R-type and I-type ALU ops.
// Latency : combinational.
// Backpressure: none. Ports: i_op5 (op[5]), i_funct3, i_funct7b5 in; o_alu_ctrl out.
module alu_op_decoder
  import mc_ctrl_pkg::*;
(
  input  logic       i_op5,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_ctrl
);

  // op[5] separates R-type from I-type: addi with Instr[30]=1 is still an add.
  logic w_is_sub;
  assign w_is_sub = i_funct7b5 & i_op5;

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_funct3)
      3'b000:  o_alu_ctrl = w_is_sub ? ALU_SUB : ALU_ADD;
      3'b001:  o_alu_ctrl = ALU_SLL;
      3'b010:  o_alu_ctrl = ALU_SLT;
      3'b011:  o_alu_ctrl = ALU_SLTU;
      3'b100:  o_alu_ctrl = ALU_XOR;
      3'b101:  o_alu_ctrl = ALU_SRL;
      3'b110:  o_alu_ctrl = ALU_OR;
      default: o_alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Purpose : multicycle RISC-V Moore control FSM (lw/sw/R/I/beq/bne/jal/lui).
// Latency : 2..5 cycles per instruction; outputs decoded from the registered state.
// Backpressure: none. Ports: clk, reset (sync, active-high), ctrl (mc_ctrl_if.master).
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mc_ctrl_if.master   ctrl
);

  state_e     r_state;
  logic [3:0] w_alu_dec;

  logic       w_pcwrite, w_adrsrc, w_memwrite, w_irwrite, w_regwrite, w_illegal;
  logic [1:0] w_resultsrc, w_alusrca, w_alusrcb;
  logic [2:0] w_immsrc;
  logic [3:0] w_aluctrl;

  alu_op_decoder u_alu_dec (
    .i_op5      (ctrl.op[5]),
    .i_funct3   (ctrl.funct3),
    .i_funct7b5 (ctrl.funct7b5),
    .o_alu_ctrl (w_alu_dec)
  );

  // State register and transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (ctrl.op)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXECUTER;
            OP_ITYPE:          r_state <= S_EXECUTEI;
            OP_BRNCH:          r_state <= S_BEQ;
            OP_JAL:            r_state <= S_JAL;
            OP_LUI:            r_state <= S_LUI;
            default:           r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= ctrl.op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_EXECUTER,
        S_EXECUTEI,
        S_JAL,
        S_LUI:      r_state <= S_ALUWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; anything not set for a state stays 0.
  always_comb begin
    w_pcwrite   = 1'b0;
    w_adrsrc    = ADR_PC;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_illegal   = 1'b0;
    w_resultsrc = RES_ALUOUT;
    w_alusrca   = SRCA_PC;
    w_alusrcb   = SRCB_RS2;
    w_immsrc    = IMM_I;
    w_aluctrl   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_pcwrite   = 1'b1;
        w_alusrcb   = SRCB_FOUR;
        w_resultsrc = RES_ALURESULT;
      end
      S_DECODE: begin
        // Branch target precomputed here so BEQ only has to compare.
        w_alusrca = SRCA_OLDPC;
        w_alusrcb = SRCB_IMM;
        w_immsrc  = IMM_B;
        w_illegal = ~op_is_legal(ctrl.op);
      end
      S_MEMADR: begin
        w_alusrca = SRCA_RS1;
        w_alusrcb = SRCB_IMM;
        w_immsrc  = ctrl.op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        w_adrsrc = ADR_RESULT;
      end
      S_MEMWB: begin
        w_resultsrc = RES_DATA;
        w_regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adrsrc   = ADR_RESULT;
        w_memwrite = 1'b1;
      end
      S_EXECUTER: begin
        w_alusrca = SRCA_RS1;
        w_alusrcb = SRCB_RS2;
        w_aluctrl = w_alu_dec;
      end
      S_EXECUTEI: begin
        w_alusrca = SRCA_RS1;
        w_alusrcb = SRCB_IMM;
        w_aluctrl = w_alu_dec;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
      end
      S_BEQ: begin
        w_alusrca = SRCA_RS1;
        w_alusrcb = SRCB_RS2;
        w_aluctrl = ALU_SUB;
        // funct3[0] flips the sense: beq takes on Zero, bne on !Zero.
        w_pcwrite = ctrl.Zero ^ ctrl.funct3[0];
      end
      S_JAL: begin
        w_alusrca = SRCA_OLDPC;
        w_alusrcb = SRCB_FOUR;
        w_pcwrite = 1'b1;
      end
      S_LUI: begin
        w_alusrcb = SRCB_IMM;
        w_immsrc  = IMM_U;
        w_aluctrl = ALU_PASSB;
      end
      default: ;
    endcase
  end

  // Reset holds FETCH, but its write strobes must stay quiet until reset drops.
  assign ctrl.PCWrite    = w_pcwrite  & ~reset;
  assign ctrl.IRWrite    = w_irwrite  & ~reset;
  assign ctrl.RegWrite   = w_regwrite & ~reset;
  assign ctrl.MemWrite   = w_memwrite & ~reset;
  assign ctrl.Illegal    = w_illegal  & ~reset;
  assign ctrl.AdrSrc     = w_adrsrc;
  assign ctrl.ResultSrc  = w_resultsrc;
  assign ctrl.ALUSrcA    = w_alusrca;
  assign ctrl.ALUSrcB    = w_alusrcb;
  assign ctrl.ImmSrc     = w_immsrc;
  assign ctrl.ALUControl = w_aluctrl;
  assign ctrl.State      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mc_ctrl_if u_if ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Expected per-cycle output vectors, in state order.
  logic [22:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] mk(input logic [3:0] st, input logic pcw, input logic adr,
                                      input logic mw, input logic irw, input logic rw,
                                      input logic [1:0] res, input logic [1:0] a,
                                      input logic [1:0] b, input logic [2:0] imm,
                                      input logic [3:0] alu, input logic ill);
    return {st, pcw, adr, mw, irw, rw, res, a, b, imm, alu, ill};
  endfunction

  function automatic logic [22:0] obs();
    return {u_if.State, u_if.PCWrite, u_if.AdrSrc, u_if.MemWrite, u_if.IRWrite,
            u_if.RegWrite, u_if.ResultSrc, u_if.ALUSrcA, u_if.ALUSrcB, u_if.ImmSrc,
            u_if.ALUControl, u_if.Illegal};
  endfunction

  // State, the four write enables and Illegal only.
  function automatic logic [8:0] obs_rst();
    return {u_if.State, u_if.PCWrite, u_if.IRWrite, u_if.RegWrite, u_if.MemWrite, u_if.Illegal};
  endfunction

  function automatic logic [3:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (f7 && op == 7'b0110011) ? 4'd1 : 4'd0;
      3'd1: return 4'd8;
      3'd2: return 4'd5;
      3'd3: return 4'd7;
      3'd4: return 4'd4;
      3'd5: return 4'd9;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  task automatic push_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    logic ill;
    ill = !(op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 || op == 7'b0010011 ||
            op == 7'b1100011 || op == 7'b1101111 || op == 7'b0110111);
    sb.push_back(mk(4'd0, 1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'd0, 4'd0, 0));
    sb.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd2, 4'd0, ill));
    case (op)
      7'b0000011: begin
        sb.push_back(mk(4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0, 0));
        sb.push_back(mk(4'd3, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
        sb.push_back(mk(4'd4, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 4'd0, 0));
      end
      7'b0100011: begin
        sb.push_back(mk(4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 4'd0, 0));
        sb.push_back(mk(4'd5, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
      end
      7'b0110011: begin
        sb.push_back(mk(4'd6, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, exp_alu(op, f3, f7), 0));
        sb.push_back(mk(4'd8, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
      end
      7'b0010011: begin
        sb.push_back(mk(4'd7, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, exp_alu(op, f3, f7), 0));
        sb.push_back(mk(4'd8, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
      end
      7'b1100011: begin
        // beq (f3=000) taken on Zero, bne (f3=001) taken on !Zero
        sb.push_back(mk(4'd9, (f3 == 3'b000) ? z : !z, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 4'd1, 0));
      end
      7'b1101111: begin
        sb.push_back(mk(4'd10, 1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 4'd0, 0));
        sb.push_back(mk(4'd8, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
      end
      7'b0110111: begin
        sb.push_back(mk(4'd11, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd4, 4'd6, 0));
        sb.push_back(mk(4'd8, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
      end
      default: ;
    endcase
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    u_if.op       = op;
    u_if.funct3   = f3;
    u_if.funct7b5 = f7;
    u_if.Zero     = z;
  endtask

  // Called #1 after a rising edge with the DUT in FETCH.
  task automatic run_instr(input int idx, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z);
    logic [22:0] e;
    int cyc;
    drive(op, f3, f7, z);
    push_instr(op, f3, f7, z);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      check_eq($sformatf("i%0d_op%b_c%0d", idx, op, cyc), {9'd0, obs()}, {9'd0, e});
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
  } stim_t;

  stim_t stim[] = '{
    '{7'b0000011, 3'b010, 1'b0, 1'b0},  // lw
    '{7'b0100011, 3'b010, 1'b0, 1'b0},  // sw
    '{7'b0110011, 3'b000, 1'b0, 1'b0},  // add
    '{7'b0110011, 3'b000, 1'b1, 1'b0},  // sub
    '{7'b0010011, 3'b000, 1'b1, 1'b0},  // addi with Instr[30]=1
    '{7'b0110011, 3'b001, 1'b0, 1'b0},  // sll
    '{7'b0110011, 3'b010, 1'b0, 1'b0},  // slt
    '{7'b0010011, 3'b011, 1'b0, 1'b0},  // sltiu
    '{7'b0010011, 3'b100, 1'b0, 1'b0},  // xori
    '{7'b0110011, 3'b101, 1'b0, 1'b0},  // srl
    '{7'b0110011, 3'b110, 1'b0, 1'b0},  // or
    '{7'b0010011, 3'b111, 1'b0, 1'b0},  // andi
    '{7'b1100011, 3'b000, 1'b0, 1'b1},  // beq taken
    '{7'b1100011, 3'b000, 1'b0, 1'b0},  // beq not taken
    '{7'b1100011, 3'b001, 1'b0, 1'b1},  // bne not taken
    '{7'b1100011, 3'b001, 1'b0, 1'b0},  // bne taken
    '{7'b1101111, 3'b000, 1'b0, 1'b0},  // jal
    '{7'b0110111, 3'b000, 1'b0, 1'b0},  // lui
    '{7'b1111111, 3'b000, 1'b0, 1'b0},  // illegal
    '{7'b0000000, 3'b000, 1'b0, 1'b0},  // illegal
    '{7'b0000011, 3'b000, 1'b0, 1'b1}   // lw after illegal
  };

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    drive(7'b0000011, 3'b000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_hold", {23'd0, obs_rst()}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (stim[i]) run_instr(i, stim[i].op, stim[i].f3, stim[i].f7, stim[i].z);

    // lw aborted by reset while in MEMREAD
    drive(7'b0000011, 3'b010, 1'b0, 1'b0);
    push_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      logic [22:0] e;
      @(negedge clk);
      e = sb.pop_front();
      check_eq($sformatf("abort_c%0d", c), {9'd0, obs()}, {9'd0, e});
      @(posedge clk);
      #1;
    end
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_memread", {23'd0, obs_rst()}, {23'd0, 4'd3, 5'b00000});
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("abort_fetch", {23'd0, obs_rst()}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(100, 7'b0100011, 3'b010, 1'b0, 1'b0);
    run_instr(101, 7'b0110011, 3'b111, 1'b1, 1'b0);

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have inputs:
- op, 7 bits: Instr[6:0].
- funct3, 3 bits: Instr[14:12].
- funct7b5, 1 bit: Instr[30].
- Zero, 1 bit: ALU zero flag.
REQ-004 SHALL have outputs:
- PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite: 1 bit each.
- ResultSrc, ALUSrcA, ALUSrcB: 2 bits each.
- ImmSrc: 3 bits.
- ALUControl: 4 bits.
- Illegal: 1 bit.
- State: 4 bits, debug.
REQ-005 SHALL use these select encodings:
- ALUSrcA: 00 PC, 01 OldPC, 10 rs1 data.
- ALUSrcB: 00 rs2 data, 01 ImmExt, 10 constant 4.
- ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult.
- AdrSrc: 0 PC, 1 Result.
- ImmSrc: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-006 SHALL use these ALUControl codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 pass-B, 0111 sltu, 1000 sll, 1001 srl.

Function
REQ-007 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, LUI.
REQ-008 FETCH SHALL assert AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10 and PCWrite=1, then go to DECODE.
REQ-009 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ImmSrc=010 and add (branch target).
REQ-009a DECODE SHALL then go to the state selected by op:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECUTER.
- 0010011 -> EXECUTEI.
- 1100011 -> BEQ.
- 1101111 -> JAL.
- 0110111 -> LUI.
REQ-010 An unlisted op in DECODE SHALL assert Illegal for that single cycle, assert no write enables, and return to FETCH.
REQ-011 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01 and add, with ImmSrc=000 for lw and 001 for sw, then go to MEMREAD (lw) or MEMWRITE (sw).
REQ-012 MEMREAD SHALL drive ResultSrc=00 and AdrSrc=1, then go to MEMWB.
REQ-012a MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-013 MEMWRITE SHALL drive ResultSrc=00, AdrSrc=1 and MemWrite=1, then go to FETCH.
REQ-014 EXECUTER SHALL drive ALUSrcA=10 and ALUSrcB=00; EXECUTEI SHALL drive ALUSrcA=10, ALUSrcB=01 and ImmSrc=000; both SHALL go to ALUWB.
REQ-015 In EXECUTER and EXECUTEI, ALUControl SHALL be decoded from funct3:
- 000 -> sub when funct7b5 & op[5], else add.
- 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
REQ-016 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-017 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, sub and ResultSrc=00, then go to FETCH.
REQ-017a In BEQ, PCWrite SHALL be combinational: Zero XOR funct3[0] (beq taken when Zero=1, bne taken when Zero=0).
REQ-018 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-019 LUI SHALL drive ImmSrc=100, ALUSrcB=01 and pass-B, then go to ALUWB.
REQ-020 Every output not named for a state SHALL be 0 in that state; no x values on any output.
REQ-021 Cycle counts SHALL be:
- lw: 5.
- sw, R-type, I-type, jal, lui: 4.
- beq/bne: 3.
- illegal: 2.
REQ-022 State SHALL output the current state encoding: FETCH=0, then the REQ-007 order through LUI=11.

Reset
REQ-023 reset high at a rising edge SHALL force FETCH on that edge from any state, including mid-instruction.
REQ-024 While reset is high, all write enables (PCWrite, IRWrite, RegWrite, MemWrite) and Illegal SHALL be 0.
REQ-025 The first FETCH actions SHALL occur in the first cycle after reset deasserts.

Structure
REQ-026 A shared package mc_ctrl_pkg SHALL hold the state enum, ALUControl codes, ImmSrc codes and the mux select constants.
REQ-027 Funct3/funct7 decoding SHALL live in one combinational sub-module, alu_op_decoder, instantiated once; the FSM stays in mc_controller.

Verification
REQ-028 lw (op 0000011): state sequence SHALL be 0,1,2,3,4,0; MemWrite=0 throughout; RegWrite=1 only in MEMWB.
REQ-029 sw (op 0100011): MemWrite=1 in exactly one cycle, with AdrSrc=1 and ImmSrc=001 in MEMADR.
REQ-030 Branch in BEQ:
- beq (funct3=000) with Zero=1 -> PCWrite=1.
- bne (funct3=001) with Zero=1 -> PCWrite=0.
- bne with Zero=0 -> PCWrite=1.
REQ-031 R-type with funct3=000, funct7b5=1 -> ALUControl=0001 in EXECUTER; the same fields with op=0010011 (addi) -> 0000 in EXECUTEI.
REQ-032 op=1111111 -> Illegal=1 in DECODE only; next state FETCH; no write enable asserted.
REQ-033 reset asserted in MEMREAD -> state 0 after that edge; MemWrite and RegWrite never asserted for the aborted lw.
